// File: rtl/vx_afu_wr_tracker.sv
// vx_afu_wr_tracker
// Pairs the AW and W handshakes of each AXI memory bank into write transactions.
// Counts the writes still waiting for their B response in each bank.
// Blocks AW on a bank once that bank reaches MAX_PENDING outstanding writes.
// Runs a drain FSM so the AFU controller can wait until every write is acknowledged.
//
// Optional feature: define AFU_WR_TRACKER_TIMEOUT_EN to add a drain watchdog.
// The watchdog abandons a drain after TIMEOUT_CYCLES cycles and sets err_timeout.
// Without the macro, err_timeout is tied to 0 and DRAIN waits indefinitely.

module vx_afu_wr_tracker #(
  parameter int NUM_BANKS      = 2,
  parameter int PENDING_SIZEW  = 12,
  parameter int MAX_PENDING    = 4095,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_BANKS-1:0]                         s_awvalid,
  output logic [NUM_BANKS-1:0]                         s_awready,
  output logic [NUM_BANKS-1:0]                         m_awvalid,
  input  logic [NUM_BANKS-1:0]                         m_awready,
  input  logic [NUM_BANKS-1:0]                         wvalid,
  input  logic [NUM_BANKS-1:0]                         wready,
  input  logic [NUM_BANKS-1:0]                         wlast,
  input  logic [NUM_BANKS-1:0]                         bvalid,
  input  logic [NUM_BANKS-1:0]                         bready,
  input  logic                                         drain_req,
  output logic                                         drain_busy,
  output logic                                         drain_done,
  output logic                                         wr_idle,
  output logic [PENDING_SIZEW+$clog2(NUM_BANKS+1)-1:0] pending_total,
  output logic                                         err_underflow,
  output logic                                         err_timeout
);

  localparam int TOT_W = PENDING_SIZEW + $clog2(NUM_BANKS + 1);
  localparam logic [PENDING_SIZEW:0] CAP = (PENDING_SIZEW + 1)'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PENDING_SIZEW-1:0] cnt_q [NUM_BANKS];
  logic [PENDING_SIZEW-1:0] cnt_d [NUM_BANKS];
  logic [NUM_BANKS-1:0]     aw_ack_q, aw_ack_d;
  logic [NUM_BANKS-1:0]     w_ack_q, w_ack_d;
  logic [NUM_BANKS-1:0]     aw_block, aw_fire, w_fire, b_fire, tx_ack;
  logic                     underflow_hit;
  logic [TOT_W-1:0]         total_now, pending_total_q;
  logic                     idle_now, wr_idle_q, err_underflow_q;
  logic                     tmo_hit;

  // Throttle AW per bank at the cap.
  // An AW that has fired but is not yet paired already counts toward the cap.
  // The whole AW path is closed while draining.
  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first so no path infers a latch.
    aw_block = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      aw_block[i] = (({1'b0, cnt_q[i]} + {{PENDING_SIZEW{1'b0}}, aw_ack_q[i]}) >= CAP)
                    || (state_q == ST_DRAIN);
    end
  end

  assign s_awready = m_awready & ~aw_block;
  assign m_awvalid = s_awvalid & ~aw_block;
  assign aw_fire   = m_awvalid & m_awready;
  assign w_fire    = wvalid & wready & wlast;
  assign b_fire    = bvalid & bready;
  assign tx_ack    = (aw_fire | aw_ack_q) & (w_fire | w_ack_q);

  // Per-bank AW/W pairing flags and outstanding-write counters.
  // A B response that arrives when the count is already 0 leaves the count at 0 and is flagged.
  always_comb begin
    aw_ack_d      = aw_ack_q;
    w_ack_d       = w_ack_q;
    underflow_hit = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tx_ack[i]) begin
        aw_ack_d[i] = 1'b0;
        w_ack_d[i]  = 1'b0;
      end else begin
        if (aw_fire[i]) aw_ack_d[i] = 1'b1;
        if (w_fire[i])  w_ack_d[i]  = 1'b1;
      end
      case ({tx_ack[i], b_fire[i]})
        2'b10: cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01: begin
          if (cnt_q[i] == '0) underflow_hit = 1'b1;
          else                cnt_d[i]      = cnt_q[i] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sum of the bank counters and the idle condition, taken from the current registered state.
  always_comb begin
    total_now = '0;
    idle_now  = ~|aw_ack_q & ~|w_ack_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      total_now = total_now + TOT_W'(cnt_q[i]);
      if (cnt_q[i] != '0) idle_now = 1'b0;
    end
  end

  // Drain FSM next state.
  // A drain requested while DRAIN or DONE is already under way is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_req)             state_d = ST_DRAIN;
      ST_DRAIN: if (wr_idle_q || tmo_hit) state_d = ST_DONE;
      ST_DONE:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other register.
      for (int i = 0; i < NUM_BANKS; i++) cnt_q[i] <= '0;
      aw_ack_q        <= '0;
      w_ack_q         <= '0;
      state_q         <= ST_IDLE;
      pending_total_q <= '0;
      wr_idle_q       <= 1'b1;
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) cnt_q[i] <= cnt_d[i];
      aw_ack_q        <= aw_ack_d;
      w_ack_q         <= w_ack_d;
      state_q         <= state_d;
      pending_total_q <= total_now;
      wr_idle_q       <= idle_now;
      if (underflow_hit) err_underflow_q <= 1'b1;
    end
  end

`ifdef AFU_WR_TRACKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_timeout_q;

  // The counter is held at zero outside DRAIN, so every drain starts counting from 0.
  // The last DRAIN cycle is the one in which the counter shows TIMEOUT_CYCLES-1.
  assign tmo_hit = (state_q == ST_DRAIN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Drain watchdog counter and its sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_q != ST_DRAIN) tmo_cnt_q <= '0;
      else                     tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (tmo_hit) err_timeout_q <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign drain_busy    = (state_q == ST_DRAIN);
  assign drain_done    = (state_q == ST_DONE);
  assign wr_idle       = wr_idle_q;
  assign pending_total = pending_total_q;
  assign err_underflow = err_underflow_q;

endmodule
